// File: rtl/vga_line_fetch_arbiter.sv
// Arbitrates the single-port video RAM between CPU bus accesses and the per-line
// display prefetch; display has priority, the CPU owns every CPU_SLOT-th fetch cycle.
module vga_line_fetch_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int LINE_WORDS = 20,
    parameter int CPU_SLOT   = 4,
    parameter int LB_AW      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [3:0]        cpu_be_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [31:0]       cpu_rdata_o,
    input  logic              line_start_i,
    input  logic [9:0]        line_idx_i,
    output logic              fetch_busy_o,
    output logic              fetch_done_o,
    output logic              overrun_o,
    output logic              lb_we_o,
    output logic [LB_AW-1:0]  lb_addr_o,
    output logic [31:0]       lb_wdata_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [3:0]        ram_be_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);
    localparam int SLOT_W = $clog2(CPU_SLOT);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CPU_SLOT - 1);
    localparam logic [LB_AW-1:0]  WORD_LAST = LB_AW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DISP} own_e;

    state_e            state_q, state_d;
    own_e              rsp_own_q, rsp_own_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LB_AW-1:0]  word_q, word_d, rsp_idx_q, rsp_idx_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              rsp_wr_q, rsp_wr_d, overrun_q, overrun_d;
    logic              busy, cpu_gnt, disp_issue, rsp_cpu, rsp_disp;

    assign busy = (state_q != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (line_start_i) state_d = S_FETCH;
            S_FETCH: begin
                if (line_start_i)                          state_d = S_FETCH;
                else if (disp_issue && word_q == WORD_LAST) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = line_start_i ? S_FETCH : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Slot ownership; rst gates both requesters off the RAM port
    always_comb begin
        cpu_gnt    = 1'b0;
        disp_issue = 1'b0;
        if (!rst) begin
            if (state_q == S_FETCH) begin
                cpu_gnt    = cpu_req_i && (slot_q == SLOT_LAST);
                disp_issue = !cpu_gnt;
            end else begin
                cpu_gnt = cpu_req_i;
            end
        end
    end

    assign cpu_gnt_o   = cpu_gnt;
    assign ram_en_o    = cpu_gnt | disp_issue;
    assign ram_we_o    = cpu_gnt & cpu_we_i;
    assign ram_be_o    = cpu_gnt ? (cpu_we_i ? cpu_be_i : 4'hF) : (disp_issue ? 4'hF : 4'h0);
    assign ram_addr_o  = cpu_gnt ? cpu_addr_i : (disp_issue ? base_q + ADDR_W'(word_q) : '0);
    assign ram_wdata_o = cpu_gnt ? cpu_wdata_i : 32'h0;

    always_comb begin
        base_d    = base_q;
        word_d    = word_q;
        slot_d    = slot_q;
        overrun_d = overrun_q | (line_start_i & busy);
        if (line_start_i) begin
            base_d = ADDR_W'(32'(line_idx_i) * 32'(LINE_WORDS));
            word_d = '0;
            slot_d = '0;
        end else if (state_q == S_FETCH) begin
            if (disp_issue) word_d = word_q + LB_AW'(1);
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
        end
        // A restart discards the display read issued in the same cycle
        if (cpu_gnt)                         rsp_own_d = OWN_CPU;
        else if (disp_issue && !line_start_i) rsp_own_d = OWN_DISP;
        else                                 rsp_own_d = OWN_NONE;
        rsp_idx_d = word_q;
        rsp_wr_d  = cpu_we_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            word_q    <= '0;
            slot_q    <= '0;
            overrun_q <= 1'b0;
            rsp_own_q <= OWN_NONE;
            rsp_idx_q <= '0;
            rsp_wr_q  <= 1'b0;
        end else begin
            base_q    <= base_d;
            word_q    <= word_d;
            slot_q    <= slot_d;
            overrun_q <= overrun_d;
            rsp_own_q <= rsp_own_d;
            rsp_idx_q <= rsp_idx_d;
            rsp_wr_q  <= rsp_wr_d;
        end
    end

    assign rsp_cpu      = (rsp_own_q == OWN_CPU);
    assign rsp_disp     = (rsp_own_q == OWN_DISP);
    assign cpu_rvalid_o = rsp_cpu;
    assign cpu_rdata_o  = (rsp_cpu && !rsp_wr_q) ? ram_rdata_i : 32'h0;
    assign lb_we_o      = rsp_disp;
    assign lb_addr_o    = rsp_disp ? rsp_idx_q : '0;
    assign lb_wdata_o   = rsp_disp ? ram_rdata_i : 32'h0;
    assign fetch_done_o = rsp_disp && (rsp_idx_q == WORD_LAST);
    assign fetch_busy_o = busy;
    assign overrun_o    = overrun_q;
endmodule

// File: doc/vga_line_fetch_arbiter.md
# vga_line_fetch_arbiter

Shares the single-port video RAM between the PULP data-bus slave port (CPU writes and reads of the frame buffer) and the VGA line prefetcher. It sequences one line-buffer fill per `line_start_i` pulse from the VGA timing generator. Display fetch has priority, and the CPU is guaranteed every `CPU_SLOT`-th cycle during a fetch. The block sits between the peripheral bus and the RAM feeding `R_o/G_o/B_o` on the Nexys A7 top.

## Interface
- `ADDR_W`, 12: RAM word-address width.
- `LINE_WORDS`, 20: words per display line; range 2..256.
- `CPU_SLOT`, 4: guaranteed CPU slot period during a fetch; must be ≥2.
- `LB_AW`, `$clog2(LINE_WORDS)`: line-buffer address width (derived).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req_i` in 1; `cpu_we_i` in 1; `cpu_be_i` in 4; `cpu_addr_i` in ADDR_W; `cpu_wdata_i` in 32: CPU request, valid while `cpu_req_i`=1.
- `cpu_gnt_o` out 1: request accepted this cycle (combinational).
- `cpu_rvalid_o` out 1; `cpu_rdata_o` out 32: response, one per grant.
- `line_start_i` in 1: one-cycle pulse requesting a fetch of row `line_idx_i`.
- `line_idx_i` in 10: row to fetch, sampled only with `line_start_i`.
- `fetch_busy_o` out 1: high in FETCH and DRAIN.
- `fetch_done_o` out 1: one-cycle pulse on the last line-buffer write.
- `overrun_o` out 1: sticky; a line start arrived while busy.
- `lb_we_o` out 1; `lb_addr_o` out LB_AW; `lb_wdata_o` out 32: line-buffer write port.
- `ram_en_o`, `ram_we_o` out 1; `ram_be_o` out 4; `ram_addr_o` out ADDR_W; `ram_wdata_o` out 32: RAM port (combinational).
- `ram_rdata_i` in 32: RAM read data, one cycle after a read.

## Operation
- States: IDLE, FETCH, DRAIN.
  - IDLE→FETCH on `line_start_i`.
  - FETCH→DRAIN in the cycle after the display issues word LINE_WORDS-1.
  - DRAIN→IDLE after one cycle.
  - `line_start_i` in FETCH or DRAIN → restart in FETCH.
- On `line_start_i`:
  - `base` ← (`line_idx_i` × LINE_WORDS) mod 2^ADDR_W. Addresses wrap mod 2^ADDR_W.
  - Word counter ← 0; slot counter ← 0.
- Slot owner each cycle:
  - IDLE, DRAIN: CPU if `cpu_req_i`.
  - FETCH: CPU if `cpu_req_i` and slot counter = CPU_SLOT-1; otherwise display.
  - The slot counter increments every FETCH cycle and wraps at CPU_SLOT-1. An unused CPU slot goes to the display.
- Display issue:
  - `ram_en_o`=1, `ram_we_o`=0, `ram_addr_o`=`base`+word counter.
  - Word counter increments.
- CPU grant:
  - `cpu_gnt_o`=1; RAM port driven from the `cpu_*` inputs; `ram_be_o`=`cpu_be_i` on writes, 4'hF on reads.
- Response register records the owner of the previous cycle's access (NONE/CPU/DISP), plus word index and the CPU write flag.
  - CPU owner: `cpu_rvalid_o`=1; `cpu_rdata_o`=`ram_rdata_i` for reads, 0 for writes.
  - DISP owner: `lb_we_o`=1, `lb_addr_o`=word index, `lb_wdata_o`=`ram_rdata_i`.
  - `fetch_done_o` pulses with the write of index LINE_WORDS-1.
- Restart while busy:
  - `overrun_o` ← 1 (held until `rst`).
  - The in-flight display read is discarded: no `lb_we_o`, no `fetch_done_o`.
  - An in-flight CPU response is still delivered.
- Simultaneous `line_start_i` and `cpu_req_i` in IDLE: the CPU is granted this cycle; the fetch starts next cycle.

## Timing
- Reset (synchronous, `rst`=1 at an edge):
  - State IDLE; counters 0; response owner NONE.
  - `overrun_o`=0; `fetch_busy_o`, `fetch_done_o`, `lb_we_o`, `cpu_rvalid_o` = 0; data outputs 0.
  - While `rst`=1, `cpu_gnt_o` and `ram_en_o` are forced 0.
  - Reset mid-fetch or mid-read drops all pending responses.
- CPU latency: grant in cycle t → `cpu_rvalid_o` in t+1. Back-to-back grants are allowed.
- Fetch latency, no CPU traffic, `line_start_i` at cycle 0:
  - Word k issued in cycle 1+k; `lb_we_o` for word k in cycle 2+k.
  - DRAIN and `fetch_done_o` in cycle LINE_WORDS+1.
  - `fetch_busy_o` high in cycles 1..LINE_WORDS+1.
- Fetch with a continuous CPU request: duration LINE_WORDS + ceil(LINE_WORDS/(CPU_SLOT-1)) - 1 + 1 cycles.
- Worst-case CPU wait during a fetch: CPU_SLOT-1 cycles.

## Test plan
1. `line_start_i`, `line_idx_i`=3, no CPU, RAM[60..79]=addr → `lb_we_o` cycles 2..21 writing idx 0..19 with data 60..79; `fetch_done_o` at cycle 21; `fetch_busy_o` low at cycle 22.
2. Same as 1 with `cpu_req_i` held high (reads) → CPU granted in fetch cycles 4,8,..,24; display issues 20 words; `fetch_done_o` at cycle 27; each grant followed by `cpu_rvalid_o` with correct data.
3. CPU write `be`=4'b0011 to addr 5, then read back in IDLE → `cpu_rvalid_o` t+1 both times; readback has only the low 16 bits updated.
4. Second `line_start_i` (`line_idx_i`=7) at fetch cycle 10 → `overrun_o`=1 sticky; no `lb_we_o` for the aborted word 9; new fetch from base 140 with idx 0..19; exactly one `fetch_done_o`.
5. `line_idx_i`=250 with ADDR_W=12 → base 5000 mod 4096 = 904; addresses 904..923.
6. `rst` asserted at fetch cycle 5 with a CPU read in flight → next cycle: all outputs 0, IDLE, no `cpu_rvalid_o`, `overrun_o`=0.
